// File: rtl/permute_controller_pkg.sv
// Shared definitions for the page-permutation sequencer: state encoding,
// job geometry constants and the control-strobe bundle.
package permute_controller_pkg;

  localparam int unsigned NUM_PAGE  = 64;
  localparam int unsigned SIZE_PAGE = 25;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_WAIT_PAGE = 3'd2,
    S_PROCESS   = 3'd3,
    S_FINISH    = 3'd4
  } state_e;

  typedef struct packed {
    logic ready;
    logic busy;
    logic page_req;
    logic page_out_valid;
    logic finished;
    logic reset;
    logic resetk;
    logic read;
    logic write;
    logic incij;
    logic inc;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/permute_controller.sv
// Sequencing FSM for the page-permutation datapath: start/init, page fetch
// handshake, per-page bit scatter, job completion and abort.
module permute_controller
  import permute_controller_pkg::*;
#(
  parameter int unsigned NUM_PAGE  = permute_controller_pkg::NUM_PAGE,
  parameter int unsigned SIZE_PAGE = permute_controller_pkg::SIZE_PAGE
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic in_valid,
  input  logic done,
  input  logic one_done,
  output logic ready,
  output logic busy,
  output logic page_req,
  output logic page_out_valid,
  output logic finished,
  output logic reset,
  output logic resetk,
  output logic read,
  output logic write,
  output logic incij,
  output logic inc
);

  // Geometry is owned by the datapath; only reject nonsensical configs.
  if (NUM_PAGE < 1 || SIZE_PAGE < 1) begin : g_cfg_check
    $error("permute_controller: NUM_PAGE and SIZE_PAGE must be >= 1");
  end

  state_e state, state_nxt;
  ctrl_t  ctrl;

  always_comb begin
    state_nxt = state;
    ctrl      = CTRL_NONE;
    ctrl.busy = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        ctrl.ready = 1'b1;
        if (start) state_nxt = S_INIT;
      end
      S_INIT: begin
        ctrl.reset  = 1'b1;
        ctrl.resetk = 1'b1;
        state_nxt   = S_WAIT_PAGE;
      end
      S_WAIT_PAGE: begin
        if (done) begin
          state_nxt = S_FINISH;
        end else begin
          ctrl.page_req = 1'b1;
          ctrl.read     = in_valid;
          if (in_valid) state_nxt = S_PROCESS;
        end
      end
      S_PROCESS: begin
        if (!one_done) begin
          ctrl.write = 1'b1;
          ctrl.incij = 1'b1;
        end else begin
          // Page complete: bump page counter and rearm the ij counter.
          ctrl.inc            = 1'b1;
          ctrl.reset          = 1'b1;
          ctrl.page_out_valid = 1'b1;
          state_nxt           = S_WAIT_PAGE;
        end
      end
      S_FINISH: begin
        ctrl.finished = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides everything; clear both datapath counters on the way out.
    if (abort && state != S_IDLE) begin
      ctrl        = CTRL_NONE;
      ctrl.busy   = 1'b1;
      ctrl.reset  = 1'b1;
      ctrl.resetk = 1'b1;
      state_nxt   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  assign ready          = ctrl.ready;
  assign busy           = ctrl.busy;
  assign page_req       = ctrl.page_req;
  assign page_out_valid = ctrl.page_out_valid;
  assign finished       = ctrl.finished;
  assign reset          = ctrl.reset;
  assign resetk         = ctrl.resetk;
  assign read           = ctrl.read;
  assign write          = ctrl.write;
  assign incij          = ctrl.incij;
  assign inc            = ctrl.inc;

endmodule

// File: tb/tb_permute_controller.sv
// Randomized bench for permute_controller: a datapath counter model closes the
// loop, and an expected per-cycle strobe trace is built from the job timeline.
module tb_permute_controller;

  localparam int NP   = 64;
  localparam int SP   = 25;
  localparam int MAXC = 4096;

  localparam logic [10:0] B_READY = 11'h400;
  localparam logic [10:0] B_BUSY  = 11'h200;
  localparam logic [10:0] B_PREQ  = 11'h100;
  localparam logic [10:0] B_POV   = 11'h080;
  localparam logic [10:0] B_FIN   = 11'h040;
  localparam logic [10:0] B_RST   = 11'h020;
  localparam logic [10:0] B_RSTK  = 11'h010;
  localparam logic [10:0] B_READ  = 11'h008;
  localparam logic [10:0] B_WRITE = 11'h004;
  localparam logic [10:0] B_INCIJ = 11'h002;
  localparam logic [10:0] B_INC   = 11'h001;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic done, one_done;
  logic ready, busy, page_req, page_out_valid, finished;
  logic reset, resetk, read, write, incij, inc;

  permute_controller #(.NUM_PAGE(NP), .SIZE_PAGE(SP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .done(done), .one_done(one_done), .ready(ready), .busy(busy),
    .page_req(page_req), .page_out_valid(page_out_valid), .finished(finished),
    .reset(reset), .resetk(resetk), .read(read), .write(write),
    .incij(incij), .inc(inc)
  );

  always #5 clk = ~clk;

  // Datapath counters: page counter k and bit counter ij.
  int k_cnt = 0, ij_cnt = 0, job_pages = 1;
  assign done     = (k_cnt == job_pages);
  assign one_done = (ij_cnt == SP);
  always @(posedge clk) begin
    if (resetk)   k_cnt <= 0;
    else if (inc) k_cnt <= k_cnt + 1;
    if (reset)      ij_cnt <= 0;
    else if (incij) ij_cnt <= ij_cnt + 1;
  end

  // Event tallies for the whole-job checks.
  int cnt_pov = 0, cnt_wr = 0, cnt_fin = 0;
  always @(posedge clk) begin
    if (page_out_valid) cnt_pov <= cnt_pov + 1;
    if (write)          cnt_wr  <= cnt_wr + 1;
    if (finished)       cnt_fin <= cnt_fin + 1;
  end

  wire [10:0] obs = {ready, busy, page_req, page_out_valid, finished,
                     reset, resetk, read, write, incij, inc};

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic        iv   [MAXC];
  logic [10:0] exp_v[MAXC];
  int          rd_cyc[NP];
  int          len;
  int          jid = 0;

  task automatic gen_iv(input int stall_pct);
    for (int c = 0; c < MAXC; c++)
      iv[c] = (c >= MAXC - 200) ? 1'b1 : ($urandom_range(99) >= stall_pct);
  endtask

  // Expected trace: start at 0, init at 1, then per page wait-for-valid,
  // SP write cycles and one completion cycle; then done check, finish, idle.
  task automatic build_exp(input int npg);
    int w, r;
    for (int c = 0; c < MAXC; c++) exp_v[c] = 11'h0;
    exp_v[0] = B_READY;
    exp_v[1] = B_BUSY | B_RST | B_RSTK;
    w = 2;
    for (int p = 0; p < npg; p++) begin
      r = w;
      while (!iv[r]) begin
        exp_v[r] = B_BUSY | B_PREQ;
        r++;
      end
      rd_cyc[p] = r;
      exp_v[r] = B_BUSY | B_PREQ | B_READ;
      for (int i = 1; i <= SP; i++) exp_v[r+i] = B_BUSY | B_WRITE | B_INCIJ;
      exp_v[r+SP+1] = B_BUSY | B_INC | B_RST | B_POV;
      w = r + SP + 2;
    end
    exp_v[w]   = B_BUSY;
    exp_v[w+1] = B_BUSY | B_FIN;
    exp_v[w+2] = B_READY;
    len = w + 3;
  endtask

  // abort_mode: 0 none, 1 random non-idle cycle, 2 mid-PROCESS of page 3.
  task automatic run_job(input int npg, input int abort_mode, input int rst_at, input bit noise);
    int abort_at;
    jid++;
    job_pages = npg;
    build_exp(npg);
    abort_at = -1;
    if (abort_mode == 1) abort_at = $urandom_range(len - 2, 1);
    if (abort_mode == 2) abort_at = rd_cyc[2] + $urandom_range(SP, 1);
    if (abort_at >= 0) begin
      exp_v[abort_at]   = B_BUSY | B_RST | B_RSTK;
      exp_v[abort_at+1] = B_READY;
      len = abort_at + 2;
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      in_valid = iv[c];
      start = (c == 0) || (noise && c < len - 1 && $urandom_range(4) == 0);
      abort = (c == abort_at) || (noise && (c == 0 || c == len - 1) && $urandom_range(1) == 1);
      if (c == rst_at) begin
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
        #1 chk($sformatf("job%0d_async_rst", jid), obs, B_READY);
        @(negedge clk);
        chk($sformatf("job%0d_rst_hold", jid), obs, B_READY);
        rst = 1'b1;
        return;
      end
      #1 chk($sformatf("job%0d_c%0d", jid, c), obs, exp_v[c]);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int w0, f0, p0;
    @(negedge clk);
    #1 chk("reset_state", obs, B_READY);
    start = 1'b1;
    abort = 1'b1;
    #1 chk("reset_ignores_start", obs, B_READY);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = $urandom_range(1);
      abort    = $urandom_range(1);
      #1 chk($sformatf("idle_c%0d", i), obs, B_READY);
    end
    abort = 1'b0;

    // Single page, no stalls.
    for (int c = 0; c < MAXC; c++) iv[c] = 1'b1;
    run_job(1, 0, -1, 1'b0);
    chk("single_page_len", len, 32);

    // Single page with a 5-cycle source stall.
    for (int c = 2; c < 7; c++) iv[c] = 1'b0;
    run_job(1, 0, -1, 1'b0);
    chk("stall_page_len", len, 37);

    // Full job, no stalls: pulse and write counts.
    for (int c = 0; c < MAXC; c++) iv[c] = 1'b1;
    w0 = cnt_wr; f0 = cnt_fin; p0 = cnt_pov;
    run_job(NP, 0, -1, 1'b0);
    chk("full_len", len, 2 + 27 * NP + 2 + 1);
    chk("full_pov", cnt_pov - p0, NP);
    chk("full_writes", cnt_wr - w0, NP * SP);
    chk("full_finished", cnt_fin - f0, 1);

    // Abort mid-PROCESS of page 3, then a clean full job.
    gen_iv(20);
    run_job(NP, 2, -1, 1'b0);
    for (int c = 0; c < MAXC; c++) iv[c] = 1'b1;
    p0 = cnt_pov;
    run_job(NP, 0, -1, 1'b0);
    chk("post_abort_pov", cnt_pov - p0, NP);

    // Illegal in_valid / start during a busy job.
    run_job(3, 0, -1, 1'b1);

    // Randomized jobs with stalls, noise and occasional aborts.
    for (int j = 0; j < 10; j++) begin
      gen_iv(30);
      run_job($urandom_range(6, 1), ($urandom_range(3) == 0) ? 1 : 0, -1, 1'b1);
    end

    // Asynchronous reset mid-job, then recovery.
    gen_iv(20);
    run_job(3, 0, $urandom_range(80, 2), 1'b1);
    gen_iv(20);
    run_job(2, 0, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/permute_controller.md
# permute_controller

Sequencing FSM for the page-permutation datapath. It accepts a start request, resets the datapath counters, and fetches input pages through a valid/request handshake. For each page it drives the 25-cycle bit-scatter into output memory, then advances the page counter until the datapath reports all pages processed. It sits between the host/stream source and the datapath, and drives every datapath control input.

## Interface
Parameters:
- NUM_PAGE, default `NUM_PAGE` (64): pages per job. Used only for bench checks; the datapath's `done` is authoritative.
- SIZE_PAGE, default `SIZE_PAGE` (25): bit writes per page. Used only for bench checks; the datapath's `one_done` is authoritative.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: job request; sampled only in IDLE.
- abort, input, 1: synchronous job cancel.
- in_valid, input, 1: source holds a page on datapath `data_in`.
- done, input, 1: datapath page counter == NUM_PAGE.
- one_done, input, 1: datapath ij counter == SIZE_PAGE.
- ready, output, 1: in IDLE, can accept start.
- busy, output, 1: job in progress, i.e. not in IDLE.
- page_req, output, 1: controller wants a page.
- page_out_valid, output, 1: 1-cycle pulse; one page is fully written to memory.
- finished, output, 1: 1-cycle pulse; job complete.
- reset, output, 1: synchronous clear of the ij counter.
- resetk, output, 1: synchronous clear of the page counter.
- read, output, 1: load the input register.
- write, output, 1: memory write enable.
- incij, output, 1: ij counter enable.
- inc, output, 1: page counter enable.

## Operation
States are IDLE, INIT, WAIT_PAGE, PROCESS and FINISH. All outputs are decoded combinationally from the state and the inputs; only the state is registered.

- **IDLE**
  - Drives ready=1; all other outputs 0.
  - start=1 → INIT.
- **INIT**
  - Drives reset=1 and resetk=1 for one cycle.
  - Always → WAIT_PAGE.
- **WAIT_PAGE**
  - If done=1 → FINISH; page_req stays 0.
  - Otherwise page_req=1 and read=page_req&in_valid.
  - On read → PROCESS; without in_valid, stay in WAIT_PAGE.
- **PROCESS**
  - While one_done=0: write=1, incij=1.
  - When one_done=1: write=0, incij=0, inc=1, reset=1, page_out_valid=1, → WAIT_PAGE.
- **FINISH**
  - Drives finished=1 for one cycle.
  - Always → IDLE.

Boundary rules:
- abort=1 in any non-IDLE state has top priority: next state IDLE, and reset=resetk=1 that cycle. Every other strobe is forced to 0 in that cycle, including write, inc, page_out_valid and finished.
- abort is ignored in IDLE. start and abort together in IDLE → INIT.
- in_valid outside WAIT_PAGE is ignored and no read is issued.
- one_done outside PROCESS and done outside WAIT_PAGE are ignored.
- start outside IDLE is ignored. A job is never restarted mid-run.
- Asynchronous reset (rst low) mid-job forces IDLE immediately; the datapath is not cleared until the next INIT.

## Timing
- Reset values (rst low): state=IDLE, ready=1, all other outputs 0.
- start sampled high in IDLE (cycle 0) → INIT in cycle 1 → WAIT_PAGE in cycle 2.
- Page handshake: the transfer occurs on the edge where page_req&in_valid=1. The source must hold data_in stable during that cycle. page_req drops the cycle after the transfer.
- Per page with in_valid already high: 1 WAIT_PAGE cycle + 25 write cycles + 1 one_done cycle = 27 cycles.
- page_out_valid coincides with the inc cycle. The memory content for that page is final at the following edge.
- The done check takes effect in the WAIT_PAGE cycle after the last inc. finished is asserted one cycle later; ready is asserted one cycle after that.
- Full job, no source stalls: 2 + 27·NUM_PAGE + 2 cycles from start to ready.
- Each in_valid stall adds exactly one cycle per stalled cycle.

## Structure
- Shared package / ISA.v: the state encoding enum/defines and the NUM_PAGE / SIZE_PAGE constants, which already exist there.
- No sub-module is needed inside permute_controller.
- A thin top `permute_top` instantiates `Datapath` plus this block, wiring the six control strobes and `done`/`one_done`.

## Test plan
- Reset then idle: hold rst low, release. ready=1 and every other output 0; start=0 for 10 cycles → no strobes.
- Single page, NUM_PAGE=1, in_valid tied high: start at cycle 0. Expect read@2, write/incij@3–27, inc+page_out_valid@28, finished@30, ready@31.
- Source stall: hold in_valid low for 5 cycles in WAIT_PAGE. page_req stays 1 and read=0; all later events shift by exactly 5 cycles.
- Full job, NUM_PAGE=64 with `Datapath` attached: exactly 64 page_out_valid pulses, 1600 write cycles, one finished pulse, and memory contents match the reference permutation per page.
- Abort at page 3, mid-PROCESS: next cycle is IDLE with reset=resetk=1 and write=0. A new start then runs a clean 64-page job.
- Illegal inputs: in_valid pulsed during PROCESS and start pulsed while busy → no extra read, no restart, and the cycle counts from the stall-free case are unchanged.
